// File: rtl/adc_capture_if.sv
// Sample-buffer write port between the ADC capture engine and the sample RAM.
//   buf_wr   : one-cycle write strobe
//   buf_addr : write address (holds its last value while buf_wr is low)
//   buf_data : write data (holds its last value while buf_wr is low)
// master = capture engine (drives), slave = buffer (receives).
interface adc_capture_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned OUT_W  = 8
);
    logic              buf_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [OUT_W-1:0]  buf_data;

    modport master (
        output buf_wr,
        output buf_addr,
        output buf_data
    );

    modport slave (
        input buf_wr,
        input buf_addr,
        input buf_data
    );
endinterface

// File: rtl/adc_capture.sv
// ADC sample capture engine: writes decimated, truncated ADC samples into the
// 2048 x 8 sample buffer after an immediate or level-crossing trigger.
// Ports:
//   clk, arst_n          system clock, async active-low reset
//   adc_data             raw unsigned ADC sample, synchronous to clk
//   arm, abort           single-cycle control pulses (abort wins over arm)
//   trig_mode/trig_level trigger select (0/3 immediate, 1 rising, 2 falling) and threshold
//   decim, depth         store every decim-th sample; store depth+1 samples
//   buf_if               buffer write port (master side)
//   busy, done, wr_count status: armed/capturing, sticky complete, samples written
module adc_capture #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned IN_W    = 12,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned DECIM_W = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [IN_W-1:0]    adc_data,
    input  logic               arm,
    input  logic               abort,
    input  logic [1:0]         trig_mode,
    input  logic [IN_W-1:0]    trig_level,
    input  logic [DECIM_W-1:0] decim,
    input  logic [ADDR_W-1:0]  depth,
    adc_capture_if.master      buf_if,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    wr_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]    adc_q, adc_prev;
    logic [1:0]         mode_q, mode_d;
    logic [IN_W-1:0]    lvl_q, lvl_d;
    logic [DECIM_W-1:0] dmax_q, dmax_d;
    logic [ADDR_W-1:0]  depth_q, depth_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DECIM_W-1:0] cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;

    logic               trig_hit_c;
    logic               trig_imm_c;
    logic               store_c;

    // Level-crossing detect on the registered sample pair.
    always_comb begin
        trig_hit_c = 1'b0;
        case (mode_q)
            TRIG_RISE: trig_hit_c = (adc_prev <  lvl_q) && (adc_q >= lvl_q);
            TRIG_FALL: trig_hit_c = (adc_prev >= lvl_q) && (adc_q <  lvl_q);
            default:   trig_hit_c = 1'b0;
        endcase
    end

    // Modes 0 and 3 both start without waiting for a crossing.
    assign trig_imm_c = (mode_q != TRIG_RISE) && (mode_q != TRIG_FALL);

    // The hit cycle itself is the first store; in CAPTURE, store on decimation phase 0.
    assign store_c = !abort &&
                     (((state_q == S_ARMED) && trig_hit_c) ||
                      ((state_q == S_CAPTURE) && (cnt_q == '0)));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lvl_d   = lvl_q;
        dmax_d  = dmax_q;
        depth_d = depth_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        count_d = count_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                        done_d  = 1'b0;
                        count_d = '0;
                        ptr_d   = '0;
                        mode_d  = trig_mode;
                        lvl_d   = trig_level;
                        // decim of 0 or 1 both mean every sample
                        dmax_d  = (decim > DECIM_W'(1)) ? (decim - DECIM_W'(1)) : '0;
                        depth_d = depth;
                    end
                end
                S_ARMED: begin
                    if (trig_imm_c) begin
                        state_d = S_CAPTURE;
                        cnt_d   = '0;
                    end else if (trig_hit_c) begin
                        // Hit cycle consumed phase 0, so capture continues at phase 1.
                        state_d = S_CAPTURE;
                        cnt_d   = (dmax_q == '0) ? '0 : DECIM_W'(1);
                    end
                end
                S_CAPTURE: begin
                    cnt_d = (cnt_q == dmax_q) ? '0 : (cnt_q + DECIM_W'(1));
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (store_c) begin
            wr_d    = 1'b1;
            addr_d  = ptr_q;
            data_d  = adc_q[IN_W-1 -: OUT_W];
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + CNT_W'(1);
            if (ptr_q == depth_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    end

    // State, input pipe and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            adc_q    <= '0;
            adc_prev <= '0;
            mode_q   <= '0;
            lvl_q    <= '0;
            dmax_q   <= '0;
            depth_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adc_q    <= adc_data;
            adc_prev <= adc_q;
            mode_q   <= mode_d;
            lvl_q    <= lvl_d;
            dmax_q   <= dmax_d;
            depth_q  <= depth_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign buf_if.buf_wr   = wr_q;
    assign buf_if.buf_addr = addr_q;
    assign buf_if.buf_data = data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wr_count        = count_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: table of capture scenarios plus
// hand-written abort, arm+abort and async-reset sequences.
module tb_adc_capture;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned IN_W    = 12;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned DECIM_W = 16;

    logic               clk = 1'b0;
    logic               arst_n;
    logic [IN_W-1:0]    adc_data;
    logic               arm;
    logic               abort;
    logic [1:0]         trig_mode;
    logic [IN_W-1:0]    trig_level;
    logic [DECIM_W-1:0] decim;
    logic [ADDR_W-1:0]  depth;
    logic               busy;
    logic               done;
    logic [ADDR_W:0]    wr_count;

    adc_capture_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bif ();

    adc_capture #(
        .ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_W(DECIM_W)
    ) dut (
        .clk(clk), .arst_n(arst_n), .adc_data(adc_data), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim), .depth(depth),
        .buf_if(bif), .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
        logic            dn;
        logic [ADDR_W:0] cnt;
    } wr_t;

    typedef struct {
        logic [1:0]         mode;
        logic [IN_W-1:0]    lvl;
        logic [DECIM_W-1:0] dec;
        logic [ADDR_W-1:0]  dep;
        logic [IN_W-1:0]    pre;
        logic [IN_W-1:0]    hit;
        int                 hold;
        bit                 ramp;
        logic [OUT_W-1:0]   exp_data;
        int                 exp_gap;
        int                 exp_n;
    } vec_t;

    int  cyc = 0;
    wr_t wq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ramp_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with the status seen alongside it.
    always @(negedge clk) begin
        wr_t w;
        if (bif.buf_wr === 1'b1) begin
            w.cyc  = cyc;
            w.addr = bif.buf_addr;
            w.data = bif.buf_data;
            w.dn   = done;
            w.cnt  = wr_count;
            wq.push_back(w);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic setup(input logic [1:0] m, input logic [IN_W-1:0] l,
                         input logic [DECIM_W-1:0] d, input logic [ADDR_W-1:0] dp,
                         input logic [IN_W-1:0] v);
        trig_mode  = m;
        trig_level = l;
        decim      = d;
        depth      = dp;
        adc_data   = v;
        step();
        step();
        wq.delete();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int arm_cyc;
        int first_exp;
        int budget;
        string tag;
        tag = $sformatf("vec%0d", idx);
        ramp_n = 0;
        setup(v.mode, v.lvl, v.dec, v.dep, v.pre);
        arm = 1'b1;
        arm_cyc = cyc;
        step();
        arm = 1'b0;
        // Config changes after arming must not take effect.
        trig_mode  = 2'd0;
        trig_level = ~v.lvl;
        decim      = 16'd9;
        depth      = '0;
        if (v.ramp) begin
            ramp_n++;
            adc_data = IN_W'(12'h100 + ramp_n);
        end
        if (v.mode == 2'd1 || v.mode == 2'd2) begin
            repeat (v.hold) step();
            chk({tag, "_busy_waiting"}, 32'(busy), 32'd1);
            chk({tag, "_no_write_before_trig"}, 32'(wq.size()), 32'd0);
            adc_data = v.hit;
            first_exp = cyc + 2;
        end else begin
            first_exp = arm_cyc + 3;
        end
        budget = 50 + v.exp_n * v.exp_gap;
        while (wq.size() < v.exp_n && budget > 0) begin
            step();
            if (v.ramp) begin
                ramp_n++;
                adc_data = IN_W'(12'h100 + ramp_n);
            end
            budget--;
        end
        repeat (6) step();
        chk({tag, "_n_writes"}, 32'(wq.size()), 32'(v.exp_n));
        for (int k = 0; k < wq.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(wq[k].addr), 32'(k));
            chk($sformatf("%s_data%0d", tag, k), 32'(wq[k].data), 32'(v.exp_data));
            chk($sformatf("%s_cyc%0d", tag, k), 32'(wq[k].cyc), 32'(first_exp + k * v.exp_gap));
            chk($sformatf("%s_done%0d", tag, k), 32'(wq[k].dn), 32'(k == v.exp_n - 1));
            chk($sformatf("%s_cnt%0d", tag, k), 32'(wq[k].cnt), 32'(k + 1));
        end
        chk({tag, "_done_final"}, 32'(done), 32'd1);
        chk({tag, "_busy_final"}, 32'(busy), 32'd0);
        chk({tag, "_wr_count_final"}, 32'(wr_count), 32'(v.exp_n));
    endtask

    vec_t vecs[9];

    initial begin
        int budget;
        //            mode   lvl      dec    dep   pre      hit      hold ramp data   gap n
        vecs[0] = '{2'd0, 12'h000, 16'd1, 11'd3, 12'h100, 12'h100, 0,   1'b1, 8'h10, 1, 4};
        vecs[1] = '{2'd1, 12'h800, 16'd1, 11'd3, 12'h7F0, 12'h810, 10,  1'b0, 8'h81, 1, 4};
        vecs[2] = '{2'd2, 12'h400, 16'd1, 11'd2, 12'h500, 12'h3F0, 100, 1'b0, 8'h3F, 1, 3};
        vecs[3] = '{2'd0, 12'h000, 16'd4, 11'd2, 12'hA50, 12'hA50, 0,   1'b0, 8'hA5, 4, 3};
        vecs[4] = '{2'd0, 12'h000, 16'd0, 11'd1, 12'h0FF, 12'h0FF, 0,   1'b0, 8'h0F, 1, 2};
        vecs[5] = '{2'd3, 12'hFFF, 16'd3, 11'd2, 12'h5A0, 12'h5A0, 0,   1'b0, 8'h5A, 3, 3};
        vecs[6] = '{2'd1, 12'h800, 16'd2, 11'd3, 12'h100, 12'h900, 5,   1'b0, 8'h90, 2, 4};
        vecs[7] = '{2'd1, 12'h800, 16'd1, 11'd0, 12'h7FF, 12'h800, 4,   1'b0, 8'h80, 1, 1};
        vecs[8] = '{2'd2, 12'h400, 16'd1, 11'd0, 12'h400, 12'h3FF, 4,   1'b0, 8'h3F, 1, 1};

        arst_n = 1'b0;
        adc_data = '0; arm = 1'b0; abort = 1'b0;
        trig_mode = '0; trig_level = '0; decim = '0; depth = '0;
        step();
        step();
        chk("rst_buf_wr", 32'(bif.buf_wr), 32'd0);
        chk("rst_buf_addr", 32'(bif.buf_addr), 32'd0);
        chk("rst_buf_data", 32'(bif.buf_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        arst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Abort after two writes of an 8-sample capture; a re-arm mid-capture is ignored.
        setup(2'd0, 12'h000, 16'd1, 11'd7, 12'h6E0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        budget = 20;
        while (wq.size() < 1 && budget > 0) begin
            step();
            budget--;
        end
        chk("abort_first_write", 32'(wq.size()), 32'd1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_next", 32'(busy), 32'd0);
        chk("abort_no_wr_next", 32'(bif.buf_wr), 32'd0);
        repeat (10) step();
        chk("abort_n_writes", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) chk("abort_addr1", 32'(wq[1].addr), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wr_count", 32'(wr_count), 32'd2);

        // Same-cycle arm and abort from IDLE: stays idle.
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        repeat (6) step();
        chk("armabort_busy", 32'(busy), 32'd0);
        chk("armabort_n_writes", 32'(wq.size()), 32'd2);
        chk("armabort_done", 32'(done), 32'd0);
        chk("armabort_wr_count", 32'(wr_count), 32'd2);

        // Async reset in the middle of a capture.
        setup(2'd0, 12'h000, 16'd4, 11'd7, 12'hC30);
        arm = 1'b1;
        step();
        arm = 1'b0;
        budget = 40;
        while (wq.size() < 2 && budget > 0) begin
            step();
            budget--;
        end
        chk("rstmid_pre_writes", 32'(wq.size()), 32'd2);
        arst_n = 1'b0;
        #1;
        chk("rstmid_buf_wr", 32'(bif.buf_wr), 32'd0);
        chk("rstmid_buf_addr", 32'(bif.buf_addr), 32'd0);
        chk("rstmid_buf_data", 32'(bif.buf_data), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_wr_count", 32'(wr_count), 32'd0);
        wq.delete();
        repeat (3) step();
        chk("rstmid_no_write", 32'(wq.size()), 32'd0);
        arst_n = 1'b1;
        step();
        run_vec(vecs[3], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
